// File: rtl/seq_multdiv_pkg.sv
// seq_multdiv_pkg -- shared definitions for the sequential multiply/divide unit.
//   state_t          : control FSM states
//   DEFAULT_WIDTH    : default operand/result width
//   cnt_width(w)     : width of the step counter, wide enough to hold w itself
package seq_multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub -- W-bit adder/subtractor shared by the Booth and restoring
// datapaths.
//   a, b  : operands
//   sub   : 1 = a - b, 0 = a + b
//   sum   : low W bits of the result
//   cout  : carry out; for subtraction, 1 means a >= b (unsigned, no borrow)
module multdiv_addsub
    import seq_multdiv_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/seq_multdiv.sv
// seq_multdiv -- sequential signed multiplier (radix-2 Booth) and optional
// restoring divider sharing one WIDTH+1-bit adder.
//   clock, reset           : rising-edge clock, async active-high reset
//   data_operandA/B        : operands, sampled only on the accepted start edge
//   ctrl_MULT / ctrl_DIV   : start requests (MULT wins when both are high)
//   data_result            : registered signed result
//   data_exception         : registered overflow / invalid flag
//   data_resultRDY         : one-cycle completion pulse (high while in DONE)
//   busy                   : high while iterating (MUL or DIV)
// Build option: define SEQ_MULTDIV_DIV_EN to include the divider. Without it a
// divide request completes immediately with result 0 and exception set.
module seq_multdiv
    import seq_multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    // acc: Booth high half / division partial remainder
    // qreg: Booth multiplier+low half / dividend shifting into quotient
    logic [WIDTH-1:0] acc, acc_n, qreg, qreg_n, mcand, mcand_n;
    logic [WIDTH-1:0] result_n;
    logic             qm1, qm1_n, exc_n;
    logic [WIDTH:0]   add_a, add_b, add_s, booth_s;
    logic             add_sub, add_co;

`ifdef SEQ_MULTDIV_DIV_EN
    logic neg, neg_n;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction
`else
    // carry out is only consumed by the divider
    logic unused_co;
    assign unused_co = add_co;
`endif

    multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        qreg_n   = qreg;
        qm1_n    = qm1;
        mcand_n  = mcand;
        result_n = data_result;
        exc_n    = data_exception;
`ifdef SEQ_MULTDIV_DIV_EN
        neg_n    = neg;
`endif
        add_a    = {acc[WIDTH-1], acc};
        add_b    = {mcand[WIDTH-1], mcand};
        add_sub  = 1'b0;
        booth_s  = {acc[WIDTH-1], acc};

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (ctrl_MULT) begin
                    acc_n   = '0;
                    qreg_n  = data_operandA;
                    qm1_n   = 1'b0;
                    mcand_n = data_operandB;
                    cnt_n   = '0;
                    state_n = MUL;
                end else if (ctrl_DIV) begin
`ifdef SEQ_MULTDIV_DIV_EN
                    acc_n   = '0;
                    qreg_n  = mag(data_operandA);
                    mcand_n = mag(data_operandB);
                    neg_n   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    cnt_n   = '0;
                    state_n = DIV;
`else
                    result_n = '0;
                    exc_n    = 1'b1;
                    state_n  = DONE;
`endif
                end
            end

            MUL: begin
                if (cnt != LAST) begin
                    // 01 -> add multiplicand, 10 -> subtract, else shift only
                    add_sub = qreg[0] & ~qm1;
                    if (qreg[0] ^ qm1)
                        booth_s = add_s;
                    // arithmetic shift right of {acc, qreg, qm1}
                    {acc_n, qreg_n, qm1_n} = {booth_s, qreg};
                    cnt_n = cnt + CW'(1);
                end else begin
                    result_n = qreg;
                    exc_n    = (acc != {WIDTH{qreg[WIDTH-1]}});
                    state_n  = DONE;
                end
            end

`ifdef SEQ_MULTDIV_DIV_EN
            DIV: begin
                if (cnt == '0 && mcand == '0) begin
                    result_n = '0;
                    exc_n    = 1'b1;
                    state_n  = DONE;
                end else if (cnt != LAST) begin
                    // trial subtract of divisor from shifted remainder
                    add_a   = {acc, qreg[WIDTH-1]};
                    add_b   = {1'b0, mcand};
                    add_sub = 1'b1;
                    acc_n   = add_co ? add_s[WIDTH-1:0] : add_a[WIDTH-1:0];
                    qreg_n  = {qreg[WIDTH-2:0], add_co};
                    cnt_n   = cnt + CW'(1);
                end else begin
                    // sign fix: negate the magnitude through the shared adder
                    add_a    = '0;
                    add_b    = {1'b0, qreg};
                    add_sub  = 1'b1;
                    result_n = neg ? add_s[WIDTH-1:0] : qreg;
                    // positive quotient of 2^(WIDTH-1) only arises from MIN / -1
                    exc_n    = ~neg & qreg[WIDTH-1];
                    state_n  = DONE;
                end
            end
`endif

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            acc            <= '0;
            qreg           <= '0;
            qm1            <= 1'b0;
            mcand          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef SEQ_MULTDIV_DIV_EN
            neg            <= 1'b0;
`endif
        end else begin
            cnt            <= cnt_n;
            acc            <= acc_n;
            qreg           <= qreg_n;
            qm1            <= qm1_n;
            mcand          <= mcand_n;
            data_result    <= result_n;
            data_exception <= exc_n;
            data_resultRDY <= (state_n == DONE);
            busy           <= (state_n == MUL) || (state_n == DIV);
`ifdef SEQ_MULTDIV_DIV_EN
            neg            <= neg_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_multdiv.sv
// tb_seq_multdiv -- directed self-checking bench for seq_multdiv (WIDTH=32).
// Latency counts the edges after the start edge E0 until data_resultRDY is
// first seen; busy counts those samples with busy high.
module tb_seq_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int errors = 0;
    int checks = 0;
    int cyc, bcnt, rdy_cnt;

    seq_multdiv #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start an op at the next edge, scramble operands afterwards, then wait
    // for RDY. poke >= 0 pulses ctrl_DIV for one edge at that cycle offset.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d, input int poke,
                          output int c, output int bc);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        c  = 0;
        bc = 0;
        while (!data_resultRDY && c < 100) begin
            ctrl_DIV = (c == poke);
            @(posedge clock); #1;
            ctrl_DIV = 1'b0;
            c++;
            if (busy) bc++;
        end
        if (!data_resultRDY) check("rdy_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", data_result, 0);
        check("rst_exc",    data_exception, 0);
        check("rst_rdy",    data_resultRDY, 0);
        check("rst_busy",   busy, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 6 x -7
        run_op(32'd6, 32'hFFFFFFF9, 1, 0, -1, cyc, bcnt);
        check("mul_6_m7_res",  data_result, 32'hFFFFFFD6);
        check("mul_6_m7_exc",  data_exception, 0);
        check("mul_6_m7_lat",  cyc, 33);
        check("mul_6_m7_busy", bcnt, 32);
        check("mul_rdy_busy",  busy, 0);
        @(posedge clock); #1;
        check("rdy_one_cycle", data_resultRDY, 0);
        check("result_held",   data_result, 32'hFFFFFFD6);

        // overflowing product
        run_op(32'h00010000, 32'h00010000, 1, 0, -1, cyc, bcnt);
        check("mul_ovf_res", data_result, 32'h00000000);
        check("mul_ovf_exc", data_exception, 1);

        // started from DONE (back-to-back)
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, -1, cyc, bcnt);
        check("mul_m1_m1_res", data_result, 32'h00000001);
        check("mul_m1_m1_exc", data_exception, 0);
        check("mul_m1_m1_lat", cyc, 33);

        run_op(32'h80000000, 32'hFFFFFFFF, 1, 0, -1, cyc, bcnt);
        check("mul_min_m1_res", data_result, 32'h80000000);
        check("mul_min_m1_exc", data_exception, 1);

        // divides
        run_op(32'hFFFFFFF9, 32'd2, 0, 1, -1, cyc, bcnt);
`ifdef SEQ_MULTDIV_DIV_EN
        check("div_m7_2_res", data_result, 32'hFFFFFFFD);
        check("div_m7_2_exc", data_exception, 0);
        check("div_m7_2_lat", cyc, 33);
`else
        check("div_off_res", data_result, 0);
        check("div_off_exc", data_exception, 1);
        check("div_off_lat", cyc, 0);
`endif

        run_op(32'h80000000, 32'hFFFFFFFF, 0, 1, -1, cyc, bcnt);
`ifdef SEQ_MULTDIV_DIV_EN
        check("div_min_m1_res", data_result, 32'h80000000);
        check("div_min_m1_exc", data_exception, 1);
`else
        check("div_off2_res", data_result, 0);
        check("div_off2_exc", data_exception, 1);
`endif

        // divide by zero: RDY seen after edge E1
        run_op(32'd5, 32'd0, 0, 1, -1, cyc, bcnt);
        check("div0_res", data_result, 0);
        check("div0_exc", data_exception, 1);
`ifdef SEQ_MULTDIV_DIV_EN
        check("div0_lat", cyc, 1);
`else
        check("div0_lat", cyc, 0);
`endif
        @(posedge clock); #1;

        // ctrl_DIV mid-multiply is ignored
        run_op(32'd3, 32'd4, 1, 0, 5, cyc, bcnt);
        check("ign_div_res", data_result, 32'h0000000C);
        check("ign_div_exc", data_exception, 0);
        check("ign_div_lat", cyc, 33);

        // both requests: multiply wins
        run_op(32'd9, 32'd3, 1, 1, -1, cyc, bcnt);
        check("both_res", data_result, 32'h0000001B);
        check("both_exc", data_exception, 0);
        check("both_lat", cyc, 33);
        @(posedge clock); #1;

        // reset mid-multiply at cycle 10
        data_operandA = 32'd5;
        data_operandB = 32'd7;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_result", data_result, 0);
        check("mid_rst_exc",    data_exception, 0);
        check("mid_rst_rdy",    data_resultRDY, 0);
        check("mid_rst_busy",   busy, 0);
        @(negedge clock);
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_cnt++;
        end
        check("no_rdy_after_rst", rdy_cnt, 0);
        check("idle_after_rst",   busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
